// File: rtl/turn_signal_sequencer_if.sv
// Switch/lamp bundle for turn_signal_sequencer. The optional brake input
// exists only when TURN_BRAKE_EN is defined.
interface turn_signal_sequencer_if;
   logic [1:0] SW;
`ifdef TURN_BRAKE_EN
   logic       brake;
`endif
   logic       tick;
   logic [2:0] NextState;
   logic [2:0] CurrentState;
   logic [2:0] LEDR_L;
   logic [2:0] LEDR_R;

`ifdef TURN_BRAKE_EN
   modport master (
      output SW, brake,
      input  tick, NextState, CurrentState, LEDR_L, LEDR_R
   );

   modport slave (
      input  SW, brake,
      output tick, NextState, CurrentState, LEDR_L, LEDR_R
   );
`else
   modport master (
      output SW,
      input  tick, NextState, CurrentState, LEDR_L, LEDR_R
   );

   modport slave (
      input  SW,
      output tick, NextState, CurrentState, LEDR_L, LEDR_R
   );
`endif
endinterface

// File: rtl/turn_signal_sequencer.sv
// Tail-light turn-signal sequencer: switch synchronizer, step prescaler, 8-state
// sequence and lamp decode. Optional brake overlay enabled by TURN_BRAKE_EN.
module turn_signal_sequencer #(
   parameter int unsigned TICK_DIV = 12_500_000
) (
   input logic                    clk,
   input logic                    reset_n,
   turn_signal_sequencer_if.slave bus
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      StIdle = 3'b000,
      StL1   = 3'b001,
      StL2   = 3'b010,
      StL3   = 3'b011,
      StR1   = 3'b100,
      StR2   = 3'b101,
      StR3   = 3'b110,
      StHaz  = 3'b111
   } state_e;

   logic [1:0]      sw_meta_q;
   logic [1:0]      req_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick;
   state_e          state_q, state_d;
   state_e          next_state;
   logic [2:0]      lamp_l, lamp_r;

   // Two-flop synchronizer; SW is driven straight from board switches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta_q <= 2'b00;
         req_q     <= 2'b00;
      end else begin
         sw_meta_q <= bus.SW;
         req_q     <= sw_meta_q;
      end
   end

   assign tick = (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Every side change or request drop goes through IDLE for one step.
   always_comb begin
      next_state = StIdle;
      unique case (req_q)
         2'b10: begin
            case (state_q)
               StIdle:  next_state = StL1;
               StL1:    next_state = StL2;
               StL2:    next_state = StL3;
               default: next_state = StIdle;
            endcase
         end
         2'b01: begin
            case (state_q)
               StIdle:  next_state = StR1;
               StR1:    next_state = StR2;
               StR2:    next_state = StR3;
               default: next_state = StIdle;
            endcase
         end
         2'b11: begin
            next_state = (state_q == StIdle) ? StHaz : StIdle;
         end
         default: begin
            next_state = StIdle;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         state_d = next_state;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      lamp_l = 3'b000;
      lamp_r = 3'b000;
      unique case (state_q)
         StL1:    lamp_l = 3'b001;
         StL2:    lamp_l = 3'b011;
         StL3:    lamp_l = 3'b111;
         StR1:    lamp_r = 3'b001;
         StR2:    lamp_r = 3'b011;
         StR3:    lamp_r = 3'b111;
         StHaz: begin
            lamp_l = 3'b111;
            lamp_r = 3'b111;
         end
         default: begin
            lamp_l = 3'b000;
            lamp_r = 3'b000;
         end
      endcase
   end

`ifdef TURN_BRAKE_EN
   logic brake_meta_q;
   logic brake_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         brake_meta_q <= 1'b0;
         brake_q      <= 1'b0;
      end else begin
         brake_meta_q <= bus.brake;
         brake_q      <= brake_meta_q;
      end
   end

   // Brake lights every side that is not currently sequencing.
   always_comb begin
      bus.LEDR_L = lamp_l;
      bus.LEDR_R = lamp_r;
      if (brake_q) begin
         case (state_q)
            StIdle: begin
               bus.LEDR_L = 3'b111;
               bus.LEDR_R = 3'b111;
            end
            StL1, StL2, StL3: bus.LEDR_R = 3'b111;
            StR1, StR2, StR3: bus.LEDR_L = 3'b111;
            default: begin
               bus.LEDR_L = lamp_l;
               bus.LEDR_R = lamp_r;
            end
         endcase
      end
   end
`else
   assign bus.LEDR_L = lamp_l;
   assign bus.LEDR_R = lamp_r;
`endif

   assign bus.tick         = tick;
   assign bus.NextState    = next_state;
   assign bus.CurrentState = state_q;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed bench for turn_signal_sequencer (TICK_DIV=4) with a queue of expected
// state/lamp triples consumed on each tick edge.
module tb_turn_signal_sequencer;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_err    = 0;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [2:0] l;
      logic [2:0] r;
   } exp_t;

   exp_t sb[$];

   turn_signal_sequencer_if sif ();

   turn_signal_sequencer #(
      .TICK_DIV (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [2:0] st, input logic [2:0] l,
                       input logic [2:0] r);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.l   = l;
      e.r   = r;
      sb.push_back(e);
   endtask

   // Wait for a tick (bounded), take the tick edge, compare against queue head.
   task automatic step_tick();
      exp_t       e;
      int         n;
      logic [2:0] st0;
      n   = 0;
      st0 = sif.CurrentState;
      while (sif.tick !== 1'b1 && n < 16) begin
         @(posedge clk);
         #1;
         n++;
         if (sif.tick !== 1'b1) chk("hold_between_ticks", sif.CurrentState, st0);
      end
      if (sif.tick !== 1'b1) begin
         chk("tick_timeout", sif.tick, 1);
      end else begin
         @(posedge clk);
         #1;
         chk("tick_one_cycle", sif.tick, 0);
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
         end else begin
            e = sb.pop_front();
            chk(e.tag, {sif.CurrentState, sif.LEDR_L, sif.LEDR_R}, {e.st, e.l, e.r});
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      sif.SW  = 2'b10;
`ifdef TURN_BRAKE_EN
      sif.brake = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", sif.CurrentState, 3'b000);
      chk("rst_ledl", sif.LEDR_L, 3'b000);
      chk("rst_ledr", sif.LEDR_R, 3'b000);
      chk("rst_tick", sif.tick, 0);
      chk("rst_next", sif.NextState, 3'b000);

      // Release: tick asserted after edge 3, consumed on edge 4.
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk("rel_tick", sif.tick, (i == 3) ? 1 : 0);
         if (i < 4) chk("rel_hold", sif.CurrentState, 3'b000);
      end
      chk("rel_first_step", {sif.CurrentState, sif.LEDR_L, sif.LEDR_R},
          {3'd1, 3'b001, 3'b000});
      chk("next_l1", sif.NextState, 3'b010);

      // Left run
      push("left_l2", 3'd2, 3'b011, 3'b000);
      push("left_l3", 3'd3, 3'b111, 3'b000);
      push("left_idle", 3'd0, 3'b000, 3'b000);
      push("left_l1", 3'd1, 3'b001, 3'b000);
      repeat (4) step_tick();

      // Side change right then left, always through IDLE
      sif.SW = 2'b01;
      push("sw_r_idle", 3'd0, 3'b000, 3'b000);
      push("right_r1", 3'd4, 3'b000, 3'b001);
      push("right_r2", 3'd5, 3'b000, 3'b011);
      repeat (3) step_tick();
      chk("next_r2", sif.NextState, 3'd6);
      sif.SW = 2'b10;
      push("sw_l_idle", 3'd0, 3'b000, 3'b000);
      push("sw_l_l1", 3'd1, 3'b001, 3'b000);
      push("sw_l_l2", 3'd2, 3'b011, 3'b000);
      repeat (3) step_tick();

      // Hazard, then release to IDLE
      sif.SW = 2'b11;
      push("haz_from_l2", 3'd0, 3'b000, 3'b000);
      push("haz_on1", 3'd7, 3'b111, 3'b111);
      push("haz_off", 3'd0, 3'b000, 3'b000);
      push("haz_on2", 3'd7, 3'b111, 3'b111);
      repeat (4) step_tick();
      sif.SW = 2'b00;
      push("off_idle1", 3'd0, 3'b000, 3'b000);
      push("off_idle2", 3'd0, 3'b000, 3'b000);
      push("off_idle3", 3'd0, 3'b000, 3'b000);
      repeat (3) step_tick();

      // Asynchronous reset while in L2
      sif.SW = 2'b10;
      push("pre_arst_l1", 3'd1, 3'b001, 3'b000);
      push("pre_arst_l2", 3'd2, 3'b011, 3'b000);
      repeat (2) step_tick();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_state", sif.CurrentState, 3'b000);
      chk("arst_ledl", sif.LEDR_L, 3'b000);
      #1;
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         chk("arst_cnt_restart", sif.tick, (i == 3) ? 1 : 0);
      end
      chk("arst_resume_l1", sif.CurrentState, 3'd1);

`ifdef TURN_BRAKE_EN
      sif.brake = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("brake_l1", {sif.CurrentState, sif.LEDR_L, sif.LEDR_R}, {3'd1, 3'b001, 3'b111});
      sif.SW = 2'b00;
      push("brake_l2", 3'd2, 3'b011, 3'b111);
      push("brake_idle", 3'd0, 3'b111, 3'b111);
      repeat (2) step_tick();
      sif.brake = 1'b0;
`endif

      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/turn_signal_sequencer.md
# turn_signal_sequencer

Next-state controller for the tail-light turn-signal datapath. It takes the left, right and hazard requests from the switches, prescales the board clock into a visible step rate, and runs the 8-state sequence. It drives the 3-bit state vector that feeds the current-state register and output-decode stage. It also produces the left and right lamp patterns directly, so it can run standalone on the board.

## Interface
- `TICK_DIV`, default 12_500_000: clock cycles per sequence step (50 MHz gives 4 Hz); legal range ≥1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `SW` input 2: raw switch requests; `SW[1]`=left, `SW[0]`=right, both=hazard; asynchronous to `clk`.
- `tick` output 1: one-cycle step strobe.
- `NextState` output 3: state the sequencer will take on the next tick.
- `CurrentState` output 3: registered sequencer state.
- `LEDR_L` output 3: left lamps; bit0 innermost.
- `LEDR_R` output 3: right lamps; bit0 innermost.
- `brake` input 1: present only with `TURN_BRAKE_EN`.

## Operation
- **Synchronizer.** `SW` passes through a 2-flop synchronizer, `req[1:0]`. Reset value is 00.
- **Prescaler.**
  - Counter `cnt` has width `$clog2(TICK_DIV)` (minimum 1).
  - Counts 0..`TICK_DIV`-1, then wraps to 0.
  - `tick` = (`cnt`==`TICK_DIV`-1), decoded from the counter register.
  - With `TICK_DIV`=1, `tick` is constantly 1 after reset.
- **State encoding.** IDLE=000, L1=001, L2=010, L3=011, R1=100, R2=101, R3=110, HAZ=111.
- **Transitions.** Evaluated on `req` at every edge where `tick`=1; otherwise hold.
  - `req`=00: any state → IDLE.
  - `req`=10 (left): IDLE→L1→L2→L3→IDLE, repeating. R1–R3 and HAZ → IDLE.
  - `req`=01 (right): IDLE→R1→R2→R3→IDLE, repeating. L1–L3 and HAZ → IDLE.
  - `req`=11 (hazard): IDLE→HAZ, HAZ→IDLE. Any L/R state → IDLE.
  - A request change mid-sequence never jumps sides directly; it always passes through IDLE for one step.
- **`NextState`.** Combinational transition function of `CurrentState` and `req`, independent of `tick`.
- **Lamp decode** (Moore, from `CurrentState`):
  - IDLE: L=000, R=000.
  - Ln: L=001/011/111 for n=1/2/3, R=000.
  - Rn: R=001/011/111 for n=1/2/3, L=000.
  - HAZ: L=111, R=111.

## Timing
- **Reset values.** `cnt`=0, `req`=00, `CurrentState`=IDLE, `tick`=0 (unless `TICK_DIV`=1), `NextState`=IDLE, `LEDR_L`=`LEDR_R`=000.
- **Reset mid-sequence** returns to IDLE immediately, asynchronously. The first tick after reset release comes `TICK_DIV` edges later.
- **Request latency.** A `SW` change is visible in `req` 2 edges later. It acts on the first tick at or after that edge, so the worst case is 2+`TICK_DIV` cycles.
- **Step rate.** State and lamps change only on the edge where `tick`=1, exactly one step per `TICK_DIV` cycles.
- **Lamp timing.** Lamps follow `CurrentState` with zero added latency.

## Configuration
- Macro `TURN_BRAKE_EN`.
- **Defined:**
  - Adds the `brake` input, passed through its own 2-flop synchronizer.
  - While the synchronized `brake` is 1, any side not being sequenced shows 111: both sides in IDLE, `LEDR_R` in L1–L3, `LEDR_L` in R1–R3.
  - HAZ is unchanged.
  - State transitions are unaffected.
- **Undefined:** no `brake` port; lamp decode exactly as above.

## Test plan
- **Reset.** `TICK_DIV`=4; hold `reset_n`=0 with `SW`=10 → `CurrentState`=000, lamps 000, `tick`=0. Release → first `tick` 4 edges later.
- **Left run.** `TICK_DIV`=4, `SW`=10 → `LEDR_L` steps 001, 011, 111, 000, 001 on consecutive ticks; `LEDR_R` stays 000; state steps 1,2,3,0,1.
- **Side change.** Right request, switch to `SW`=10 while in R2 → next tick IDLE, following tick L1. Never R→L directly.
- **Hazard.** `SW`=11 from IDLE → alternates 111/111 and 000/000 per tick. Set `SW`=00 while in HAZ → IDLE and stays.
- **Async reset mid-sequence.** `reset_n` low for less than a cycle while in L2 → `CurrentState`=000 before the next clock edge; `cnt` restarts.
- **Brake** (`TURN_BRAKE_EN`). `brake`=1, `SW`=10, state L1 → `LEDR_L`=001, `LEDR_R`=111. `brake`=1 in IDLE → both 111.
